reg32_load_en: RTL and testbench

//   Parameterised storage register with synchronous load enable and asynchronous active-low clear.
//   - Default configuration is a 32-bit register.
//   - Basic state element for the datapath (register-file entries, pipeline/holding registers).
//   - Captures `in` on a rising clk edge when `l_en` is high; otherwise holds its value.

---
 rtl/reg32_load_en.sv | 24 ++
 tb/tb_reg32_load_en.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg32_load_en.sv
// Storage register with a synchronous load enable and an asynchronous active-low clear.
// Default configuration is a 32-bit register that clears to zero.
// Used for register-file entries and pipeline/holding registers.
module reg32_load_en #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Storage flop: clears at once while reset is low, loads in on a rising clk when l_en is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= RESET_VAL;
        end else if (l_en) begin
            out <= in;
        end
    end

endmodule

// File: tb/tb_reg32_load_en.sv
// Self-checking bench for reg32_load_en: directed scenarios followed by random load/hold/clear traffic.
// A plain expected-value model is updated at every rising edge and on every reset assertion.
module tb_reg32_load_en;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             l_en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    logic [WIDTH-1:0] model;
    int               checks;
    int               errors;

    reg32_load_en #(
        .WIDTH    (WIDTH),
        .RESET_VAL('0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .l_en (l_en),
        .in   (in),
        .out  (out)
    );

    // 20 ns clock period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Compare one observed value against the expected one and count the comparison.
    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle starting just after a falling edge; check just after the next rising edge,
    // then return at the following falling edge.
    task automatic cycle(input string tag, input logic l, input logic [WIDTH-1:0] d);
        l_en = l;
        in   = d;
        if (reset && l) model = d;
        @(posedge clk);
        #1;
        check(tag, out, model);
        @(negedge clk);
    endtask

    // Assert reset between edges; the register must clear without a clock edge.
    task automatic assert_reset(input string tag);
        reset = 1'b0;
        model = '0;
        #1;
        check(tag, out, model);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = '0;
        reset  = 1'b0;
        l_en   = 1'b0;
        in     = '0;
        #1;
        check("reset_value", out, model);
        @(negedge clk);

        // Reset hold: in alternates, nothing loads
        for (int i = 0; i < 4; i++)
            cycle("reset_hold", 1'b0, (i % 2 == 0) ? 32'd2 : 32'd4);

        // Reset overrides load enable
        cycle("reset_over_load", 1'b1, 32'd2);
        cycle("reset_over_load", 1'b1, 32'd4);

        // Release reset between edges, then load 2 and 4
        reset = 1'b1;
        #1;
        check("release_no_edge", out, model);
        cycle("load_2", 1'b1, 32'd2);
        cycle("load_4", 1'b1, 32'd4);

        // Hold with l_en low
        for (int i = 0; i < 4; i++)
            cycle("hold", 1'b0, (i % 2 == 0) ? 32'd2 : 32'd4);

        // in changes mid-cycle: only the value present at the edge is captured
        l_en = 1'b1;
        in   = 32'd7;
        #4;
        check("mid_cycle_pre_edge", out, model);
        in    = 32'd9;
        model = 32'd9;
        @(posedge clk);
        #1;
        check("mid_cycle_edge", out, model);
        @(negedge clk);

        // l_en pulse between edges has no effect
        l_en = 1'b1;
        in   = 32'h1234_5678;
        #3;
        l_en = 1'b0;
        @(posedge clk);
        #1;
        check("l_en_glitch", out, model);
        @(negedge clk);

        // Async clear from all-ones, then stays clear with l_en high
        cycle("load_ones", 1'b1, 32'hFFFF_FFFF);
        #2;
        assert_reset("async_clear");
        cycle("clear_with_load", 1'b1, 32'hDEAD_BEEF);

        // Full-width data patterns
        reset = 1'b1;
        cycle("full_a5", 1'b1, 32'hA5A5_5A5A);
        cycle("full_msb_lsb", 1'b1, 32'h8000_0001);

        // Random traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                if (reset) begin
                    #($urandom_range(1, 5));
                    assert_reset("rand_clear");
                end else begin
                    reset = 1'b1;
                end
            end
            cycle("rand", 1'($urandom_range(0, 1)), 32'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
